vga_frame_checker: RTL and testbench
====================================

Name: vga_frame_checker

Overview:
- In-circuit monitor that sits directly downstream of the pattern display circuit and taps the same VGA_R/G/B/HS/VS nets that drive the connector.
- Measures line and frame timing, counts active pixels, and computes a per-frame 16-bit signature over the active-area pixels.
- Flags any timing deviation from the 640x480 VGA parameters, so frames are checked in hardware without a simulation file dump.

Parameters:
HACT, 640, active pixels per line
HWIDTH, 96, HS pulse width (pixel clocks)
HBACK, 48, horizontal back porch
HTOTAL, 800, pixel clocks per line
VACT, 480, active lines per frame
VWIDTH, 2, VS pulse width (lines)
VBACK, 33, vertical back porch
VTOTAL, 525, lines per frame

Ports:
CLK  in  1  pixel clock (same clock that drives the VGA outputs)
RST  in  1  reset, asynchronous, active-high
VGA_R  in  4  red
VGA_G  in  4  green
VGA_B  in  4  blue
VGA_HS  in  1  horizontal sync, active-low
VGA_VS  in  1  vertical sync, active-low
ERR_CLR  in  1  synchronous clear of TIMING_ERR
FRAME_DONE  out  1  one-cycle pulse when results update
FRAME_SIG  out  16  signature of last completed frame
PIXCNT  out  20  active pixels counted in last frame
HTOTAL_MEAS  out  12  clocks between the last two HS falling edges
VTOTAL_MEAS  out  11  lines in last frame
TIMING_ERR  out  1  sticky mismatch flag

Behaviour:
- One clock, CLK. Reset asynchronous, active-high on RST. All outputs and internal state are 0 while RST=1.
- Input stage: {R,G,B,HS,VS} are registered into s1, then s1 into s2. An HS fall is s2.HS=1 and s1.HS=0; VS fall is detected the same way. The pixel used in any cycle is s1.
- hpos (12b):
  - Loads 0 in the HS-fall cycle; otherwise increments, saturating at 4095.
  - On an HS fall, hpos+1 is latched into HTOTAL_MEAS (saturated 4095) the same cycle. The first HS fall after reset latches nothing.
- vline (11b):
  - Loads 0 on a VS fall.
  - Otherwise increments on each HS fall, saturating at 2047.
  - When a VS fall and an HS fall coincide, vline loads 0; the HS fall is not counted.
- Active pixel: HWIDTH+HBACK <= hpos < HWIDTH+HBACK+HACT and VWIDTH+VBACK <= vline < VWIDTH+VBACK+VACT, with hpos/vline values taken before this cycle's update. Active pixels increment the pixel counter (20b, wraps) and update the signature.
- FSM states:
  - IDLE (after reset): the first VS fall goes to RUN. Counters are cleared; no FRAME_DONE is produced.
  - RUN: each VS fall latches FRAME_SIG, PIXCNT, and VTOTAL_MEAS = vline+1 (saturated 2047) on the next edge, with FRAME_DONE=1 for exactly that one cycle. The pixel counter and signature reinitialise the same cycle. Stays in RUN.
- Latency: FRAME_DONE is high 3 CLK edges after VGA_VS is first sampled low.
- TIMING_ERR:
  - Set at the FRAME_DONE edge if HTOTAL_MEAS != HTOTAL, VTOTAL_MEAS != VTOTAL, or the latched pixel count != HACT*VACT. Otherwise it holds its value.
  - ERR_CLR clears it. If ERR_CLR and a set condition occur in the same cycle, set wins.
- Sync held high forever: no FRAME_DONE, outputs hold.
- RST asserted mid-frame: partial results are discarded and the FSM returns to IDLE.

Optional Feature:
- Macro: FRMCHK_CRC_EN.
- Defined: signature is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, no reflection, no final XOR). The 12 bits {R,G,B} (R[3] first) are processed in one cycle per active pixel.
- Undefined: signature is a 16-bit wrapping sum of zero-extended {R,G,B}, init 0x0000.

Test Plan:
1. Nominal 640x480 timing (800x525), constant pixel 0x000, two frames after reset -> one FRAME_DONE pulse, per VS fall after the first. HTOTAL_MEAS=800, VTOTAL_MEAS=525, PIXCNT=307200, TIMING_ERR=0; sum-mode FRAME_SIG=0x0000.
2. Same timing, constant pixel 0xFFF, macro undefined -> FRAME_SIG=0x5000. With FRMCHK_CRC_EN, FRAME_SIG matches the reference-model CRC, and frame 2 equals frame 1.
3. One line shortened to 799 clocks -> HTOTAL_MEAS=799 after that line; TIMING_ERR=1 at the next FRAME_DONE and stays 1. Pulse ERR_CLR -> 0; the next clean frame keeps it 0.
4. Frame with 524 lines -> VTOTAL_MEAS=524, PIXCNT=307200 or less as per window, TIMING_ERR=1.
5. RST asserted for 10 cycles mid-frame -> all outputs 0. The first VS fall afterwards gives no FRAME_DONE; the second gives correct full-frame values.
6. ERR_CLR asserted in the same cycle as a mismatching FRAME_DONE -> TIMING_ERR=1.

Source files
------------

// File: rtl/vga_frame_checker.sv
`default_nettype none
// vga_frame_checker: in-circuit VGA timing monitor with per-frame pixel count and signature.
// Define FRMCHK_CRC_EN for a CRC-16-CCITT signature; otherwise a 16-bit wrapping sum is used.
module vga_frame_checker #(
  parameter int HACT   = 640,
  parameter int HWIDTH = 96,
  parameter int HBACK  = 48,
  parameter int HTOTAL = 800,
  parameter int VACT   = 480,
  parameter int VWIDTH = 2,
  parameter int VBACK  = 33,
  parameter int VTOTAL = 525
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        ERR_CLR,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_SIG,
  output logic [19:0] PIXCNT,
  output logic [11:0] HTOTAL_MEAS,
  output logic [10:0] VTOTAL_MEAS,
  output logic        TIMING_ERR
);

  localparam logic [11:0] H_START = 12'(HWIDTH + HBACK);
  localparam logic [11:0] H_END   = 12'(HWIDTH + HBACK + HACT);
  localparam logic [10:0] V_START = 11'(VWIDTH + VBACK);
  localparam logic [10:0] V_END   = 11'(VWIDTH + VBACK + VACT);
  localparam logic [11:0] H_NOM   = 12'(HTOTAL);
  localparam logic [10:0] V_NOM   = 11'(VTOTAL);
  localparam logic [19:0] PIX_NOM = 20'(HACT * VACT);
`ifdef FRMCHK_CRC_EN
  localparam logic [15:0] SIG_INIT = 16'hFFFF;
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] s1_pix;
  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic        hs_fall, vs_fall, active;
  logic        start_frame, latch_now, accumulate, mismatch;
  logic [11:0] hpos;
  logic [10:0] vline, vline_snap;
  logic        hs_seen;
  logic [19:0] pix_cnt;
  logic [15:0] sig;

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [11:0] p);
`ifdef FRMCHK_CRC_EN
    logic [15:0] c;
    logic        fb;
    c = s;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ p[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
`else
    return s + {4'h0, p};
`endif
  endfunction

  assign hs_fall = s2_hs & ~s1_hs;
  assign vs_fall = s2_vs & ~s1_vs;
  assign active  = (hpos >= H_START) && (hpos < H_END) &&
                   (vline >= V_START) && (vline < V_END);
  assign mismatch = (HTOTAL_MEAS != H_NOM) || (vline_snap != V_NOM) ||
                    (pix_cnt != PIX_NOM);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_pix <= '0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
    end else begin
      s1_pix <= {VGA_R, VGA_G, VGA_B};
      s1_hs  <= VGA_HS;
      s1_vs  <= VGA_VS;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
    end
  end

  // Line/frame position and timing measurement run regardless of FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hpos        <= '0;
      hs_seen     <= 1'b0;
      HTOTAL_MEAS <= '0;
      vline       <= '0;
      vline_snap  <= '0;
    end else begin
      if (hs_fall) begin
        hpos    <= '0;
        hs_seen <= 1'b1;
        if (hs_seen)
          HTOTAL_MEAS <= (hpos == 12'hFFF) ? 12'hFFF : hpos + 12'd1;
      end else if (hpos != 12'hFFF) begin
        hpos <= hpos + 12'd1;
      end

      if (vs_fall) begin
        vline      <= '0;
        vline_snap <= (vline == 11'h7FF) ? 11'h7FF : vline + 11'd1;
      end else if (hs_fall && vline != 11'h7FF) begin
        vline <= vline + 11'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Results are published one cycle after the VS fall so the line count
  // captured at the fall is settled in vline_snap.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    latch_now   = 1'b0;
    accumulate  = 1'b0;
    case (state)
      IDLE: begin
        if (vs_fall) begin
          state_nxt   = RUN;
          start_frame = 1'b1;
        end
      end
      RUN: begin
        accumulate = 1'b1;
        if (vs_fall) state_nxt = LATCH;
      end
      LATCH: begin
        latch_now = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pix_cnt <= '0;
      sig     <= '0;
    end else if (start_frame || latch_now) begin
      pix_cnt <= '0;
      sig     <= SIG_INIT;
    end else if (accumulate && active) begin
      pix_cnt <= pix_cnt + 20'd1;
      sig     <= sig_step(sig, s1_pix);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FRAME_DONE  <= 1'b0;
      FRAME_SIG   <= '0;
      PIXCNT      <= '0;
      VTOTAL_MEAS <= '0;
      TIMING_ERR  <= 1'b0;
    end else begin
      FRAME_DONE <= latch_now;
      if (latch_now) begin
        FRAME_SIG   <= sig;
        PIXCNT      <= pix_cnt;
        VTOTAL_MEAS <= vline_snap;
      end
      if (latch_now && mismatch) TIMING_ERR <= 1'b1;
      else if (ERR_CLR)          TIMING_ERR <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_checker.sv
`default_nettype none
// tb_vga_frame_checker: scoreboard bench driving scaled-down VGA frames into vga_frame_checker.
module tb_vga_frame_checker;

  localparam int HACT = 8, HWIDTH = 2, HBACK = 2, HTOTAL = 16;
  localparam int VACT = 6, VWIDTH = 1, VBACK = 2, VTOTAL = 12;
  // A driven column hc is seen by the checker with hpos = hc-1.
  localparam int HA0 = HWIDTH + HBACK + 1;
  localparam int HA1 = HA0 + HACT;
  localparam int VA0 = VWIDTH + VBACK;
  localparam int VA1 = VA0 + VACT;
`ifdef FRMCHK_CRC_EN
  localparam logic [15:0] SIG_INIT = 16'hFFFF;
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, ERR_CLR;
  logic        FRAME_DONE, TIMING_ERR;
  logic [15:0] FRAME_SIG;
  logic [19:0] PIXCNT;
  logic [11:0] HTOTAL_MEAS;
  logic [10:0] VTOTAL_MEAS;

  typedef struct packed {
    logic [15:0] sig;
    logic [19:0] pc;
    logic [11:0] ht;
    logic [10:0] vt;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t pending, last_pushed, mon_e;
  bit   armed;
  bit   exp_err;
  int   checks = 0;
  int   errors = 0;

  vga_frame_checker #(
    .HACT(HACT), .HWIDTH(HWIDTH), .HBACK(HBACK), .HTOTAL(HTOTAL),
    .VACT(VACT), .VWIDTH(VWIDTH), .VBACK(VBACK), .VTOTAL(VTOTAL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .ERR_CLR(ERR_CLR),
    .FRAME_DONE(FRAME_DONE), .FRAME_SIG(FRAME_SIG), .PIXCNT(PIXCNT),
    .HTOTAL_MEAS(HTOTAL_MEAS), .VTOTAL_MEAS(VTOTAL_MEAS), .TIMING_ERR(TIMING_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sig_model(input logic [15:0] s, input logic [11:0] p);
`ifdef FRMCHK_CRC_EN
    logic [15:0] c;
    c = s;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ p[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
`else
    return s + {4'h0, p};
`endif
  endfunction

  function automatic logic [11:0] pixel_of(input int kind, input int line, input int hc);
    case (kind)
      0:       return 12'h000;
      1:       return 12'hFFF;
      default: return 12'((line * 16 + hc) * 37 + 5);
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_frame_done"}, FRAME_DONE, 0);
    check({tag, "_frame_sig"}, FRAME_SIG, 0);
    check({tag, "_pixcnt"}, PIXCNT, 0);
    check({tag, "_htotal"}, HTOTAL_MEAS, 0);
    check({tag, "_vtotal"}, VTOTAL_MEAS, 0);
    check({tag, "_timing_err"}, TIMING_ERR, 0);
  endtask

  task automatic drive_cycle(input logic hs, input logic vs, input logic [11:0] p, input logic clr);
    VGA_HS = hs;
    VGA_VS = vs;
    {VGA_R, VGA_G, VGA_B} = p;
    ERR_CLR = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 12'h000, 1'b0);
  endtask

  // clr_mode: 0 none, 1 ERR_CLR mid-frame, 2 ERR_CLR on the cycle results of the
  // previous frame are latched.
  task automatic send_frame(input int nlines, input int last_len, input int kind, input int clr_mode);
    logic [15:0] s;
    logic [19:0] pc;
    logic [11:0] p;
    logic        clr, mism;
    int          len;
    s  = SIG_INIT;
    pc = '0;
    for (int line = 0; line < nlines; line++) begin
      len = (line == nlines - 1) ? last_len : HTOTAL;
      for (int hc = 0; hc < len; hc++) begin
        if (line == 0 && hc == 0) begin
          if (armed) begin
            mism = (pending.ht != 12'(HTOTAL)) || (pending.vt != 11'(VTOTAL)) ||
                   (pending.pc != 20'(HACT * VACT));
            if (mism)               exp_err = 1'b1;
            else if (clr_mode == 2) exp_err = 1'b0;
            pending.err = exp_err;
            q.push_back(pending);
            last_pushed = pending;
          end
          armed = 1'b1;
        end
        clr = 1'b0;
        if (clr_mode == 2 && line == 0 && hc == 2) clr = 1'b1;
        if (clr_mode == 1 && line == 5 && hc == 3) begin
          clr = 1'b1;
          exp_err = 1'b0;
        end
        if (clr_mode == 1 && line == 5 && hc == 6) check("err_clr_mid", TIMING_ERR, 0);
        p = pixel_of(kind, line, hc);
        if (line >= VA0 && line < VA1 && hc >= HA0 && hc < HA1) begin
          pc = pc + 20'd1;
          s  = sig_model(s, p);
        end
        drive_cycle(hc >= HWIDTH, line >= VWIDTH, p, clr);
      end
    end
    pending.sig = s;
    pending.pc  = pc;
    pending.ht  = 12'(last_len);
    pending.vt  = 11'(nlines);
    pending.err = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got FRAME_DONE=1 expected 0 at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check("frame_sig", FRAME_SIG, mon_e.sig);
        check("pixcnt", PIXCNT, mon_e.pc);
        check("htotal_meas", HTOTAL_MEAS, mon_e.ht);
        check("vtotal_meas", VTOTAL_MEAS, mon_e.vt);
        check("timing_err", TIMING_ERR, mon_e.err);
      end
    end
  end

  initial begin
    RST = 1'b1;
    ERR_CLR = 1'b0;
    VGA_HS = 1'b1;
    VGA_VS = 1'b1;
    {VGA_R, VGA_G, VGA_B} = '0;
    armed = 1'b0;
    exp_err = 1'b0;
    pending = '0;
    last_pushed = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    RST = 1'b0;
    idle(4);

    send_frame(12, 16, 0, 0);   // first VS fall only arms the checker
    send_frame(12, 16, 0, 0);   // nominal, black
    send_frame(12, 16, 1, 0);   // white
    send_frame(12, 16, 1, 0);   // white again, same signature
    send_frame(12, 16, 2, 0);   // varied pixels
    send_frame(12, 15, 2, 0);   // short final line
    send_frame(12, 16, 2, 1);   // mid-frame clear
    send_frame(11, 16, 0, 0);   // one line short
    send_frame(12, 16, 1, 2);   // clear collides with mismatching latch

    fork
      send_frame(12, 16, 2, 0);
      begin
        repeat (50) @(posedge CLK);
        #2;
        RST = 1'b1;
        armed = 1'b0;
        exp_err = 1'b0;
        @(posedge CLK);
        #2;
        check_outputs_zero("midreset");
        repeat (9) @(posedge CLK);
        #2;
        RST = 1'b0;
      end
    join

    send_frame(12, 16, 1, 0);   // first VS fall after reset: no result
    send_frame(12, 16, 0, 0);   // publishes the previous white frame
    idle(100);                  // syncs stuck high: outputs must hold

    check("hold_frame_done", FRAME_DONE, 0);
    check("hold_frame_sig", FRAME_SIG, last_pushed.sig);
    check("hold_pixcnt", PIXCNT, last_pushed.pc);
    check("hold_htotal", HTOTAL_MEAS, last_pushed.ht);
    check("hold_vtotal", VTOTAL_MEAS, last_pushed.vt);
    check("hold_timing_err", TIMING_ERR, last_pushed.err);
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
